// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sched_pkg
// Purpose  : Shared types and helpers for the ALU reservation-station
//            scheduler (entry vector, age matrix, lowest-set-bit pick).
// Revision : 1.0 - initial release
// ============================================================================
package alu_sched_pkg;

  localparam int RS         = 3;
  localparam int RS_ENTRIES = RS + 1;

  typedef logic [RS:0]    rs_vec_t;
  typedef rs_vec_t [RS:0] age_mat_t;

  // One-hot vector marking the lowest-index set bit of v (zero if v is zero)
  function automatic rs_vec_t lowest_set(input rs_vec_t v);
    rs_vec_t r;
    r = '0;
    for (int i = RS; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage : alu_sched_pkg
`default_nettype wire

// File: rtl/alu_age_select.sv
`default_nettype none
// ============================================================================
// Module   : alu_age_select
// Purpose  : Age matrix for the ALU reservation station plus the
//            oldest-first pick among eligible entries. age[i][j]=1 means
//            entry i is older than entry j.
// Revision : 1.0 - initial release
// ============================================================================
module alu_age_select
  import alu_sched_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  rs_vec_t i_alloc,
  input  rs_vec_t i_eligible,
  output rs_vec_t o_pick
);

  age_mat_t r_age;
  age_mat_t w_age_nxt;
  rs_vec_t  w_blocked;

  // A newly allocated entry becomes younger than every other entry; its own
  // row is wiped so stale ordering from a previous occupant cannot leak in.
  always_comb begin
    w_age_nxt = r_age;
    for (int k = 0; k <= RS; k++) begin
      if (i_alloc[k]) begin
        w_age_nxt[k] = '0;
        for (int i = 0; i <= RS; i++) begin
          if (i != k) w_age_nxt[i][k] = 1'b1;
        end
      end
    end
  end

  // Age matrix register
  always_ff @(posedge clk) begin
    if (rst) r_age <= '0;
    else     r_age <= w_age_nxt;
  end

  // An eligible entry wins unless some other eligible entry is older
  always_comb begin
    w_blocked = '0;
    for (int i = 0; i <= RS; i++) begin
      for (int j = 0; j <= RS; j++) begin
        if (j != i && i_eligible[j] && r_age[j][i]) w_blocked[i] = 1'b1;
      end
    end
    o_pick = i_eligible & ~w_blocked;
  end

endmodule : alu_age_select
`default_nettype wire

// File: rtl/alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_scheduler
// Purpose  : Allocation / issue controller for the four-entry ALU
//            reservation station. Allocates the lowest free entry and grants
//            one ready entry per cycle to the ALU.
// Config   : ALU_SCHED_AGE_EN - defined: oldest-first selection through the
//            age matrix; undefined: fixed priority, lowest eligible wins.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs_scheduler
  import alu_sched_pkg::*;
#(
  parameter int RS = 3
) (
  input  logic        clk,
  input  logic        globalReset,
  input  logic        clear,
  input  logic        dispatchValid,
  input  logic        aluReady,
  input  logic [RS:0] busy,
  input  logic [RS:0] requests,
  output logic [RS:0] writeRequests,
  output logic        dispatchStall,
  output logic [RS:0] grants,
  output logic        execute,
  output logic        issueValid
);

  rs_vec_t r_alloc_pend;
  rs_vec_t r_grant_pend;
  logic    r_issue_valid;

  rs_vec_t w_free;
  rs_vec_t w_eligible;
  rs_vec_t w_pick;
  logic    w_kill;

  assign w_kill = clear | globalReset;

  // Allocation: allocPend masks an entry until its busy flag shows up
  always_comb begin
    w_free        = ~busy & ~r_alloc_pend;
    writeRequests = (dispatchValid && !w_kill) ? lowest_set(w_free) : '0;
    dispatchStall = dispatchValid && !globalReset && (w_free == '0);
  end

  // An entry granted last cycle is still busy/requesting; hide it for a cycle
  assign w_eligible = requests & ~r_grant_pend;

`ifdef ALU_SCHED_AGE_EN
  alu_age_select u_age_select (
    .clk        (clk),
    .rst        (w_kill),
    .i_alloc    (writeRequests),
    .i_eligible (w_eligible),
    .o_pick     (w_pick)
  );
`else
  assign w_pick = lowest_set(w_eligible);
`endif

  // Issue: nothing is granted while the ALU is full or the pipe is flushing
  always_comb begin
    grants  = (aluReady && !w_kill) ? w_pick : '0;
    execute = |grants;
  end

  // Pending masks and the issue-valid flag track the station registers
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_alloc_pend  <= '0;
      r_grant_pend  <= '0;
      r_issue_valid <= 1'b0;
    end else begin
      r_alloc_pend  <= writeRequests;
      r_grant_pend  <= grants;
      r_issue_valid <= execute;
    end
  end

  assign issueValid = r_issue_valid;

endmodule : alu_rs_scheduler
`default_nettype wire

// File: tb/tb_alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs_scheduler
// Purpose  : Directed self-checking bench for alu_rs_scheduler.
// Config   : ALU_SCHED_AGE_EN selects the oldest-first expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rs_scheduler;

  logic       clk = 1'b0;
  logic       globalReset;
  logic       clear;
  logic       dispatchValid;
  logic       aluReady;
  logic [3:0] busy;
  logic [3:0] requests;
  logic [3:0] writeRequests;
  logic       dispatchStall;
  logic [3:0] grants;
  logic       execute;
  logic       issueValid;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALU_SCHED_AGE_EN
  localparam logic [3:0] EXP_G_AGE1  = 4'b0100;
  localparam logic [3:0] EXP_G_CLEAR = 4'b1000;
`else
  localparam logic [3:0] EXP_G_AGE1  = 4'b0001;
  localparam logic [3:0] EXP_G_CLEAR = 4'b0010;
`endif

  alu_rs_scheduler #(.RS(3)) dut (
    .clk           (clk),
    .globalReset   (globalReset),
    .clear         (clear),
    .dispatchValid (dispatchValid),
    .aluReady      (aluReady),
    .busy          (busy),
    .requests      (requests),
    .writeRequests (writeRequests),
    .dispatchStall (dispatchStall),
    .grants        (grants),
    .execute       (execute),
    .issueValid    (issueValid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Advance one edge, then let the registered and combinational values settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    globalReset   = 1'b1;
    clear         = 1'b0;
    dispatchValid = 1'b1;
    aluReady      = 1'b1;
    busy          = 4'b0000;
    requests      = 4'b1111;
    tick();
    tick();
    check_val("rst_wr",    {4'b0, writeRequests}, 8'h00);
    check_val("rst_grant", {4'b0, grants},        8'h00);
    check_val("rst_exe",   {7'b0, execute},       8'h00);
    check_val("rst_stall", {7'b0, dispatchStall}, 8'h00);
    check_val("rst_iv",    {7'b0, issueValid},    8'h00);

    // Back-to-back allocation with busy lagging
    globalReset = 1'b0;
    requests    = 4'b0000;
    aluReady    = 1'b0;
    #1;
    check_val("alloc_first",  {4'b0, writeRequests}, 8'b0000_0001);
    tick();
    check_val("alloc_second", {4'b0, writeRequests}, 8'b0000_0010);
    dispatchValid = 1'b0;
    tick();
    tick();

    // Allocate entries 2, 0, 3
    dispatchValid = 1'b1;
    busy          = 4'b0011;
    #1;
    check_val("alloc_e2", {4'b0, writeRequests}, 8'b0000_0100);
    tick();
    busy = 4'b0110;
    #1;
    check_val("alloc_e0", {4'b0, writeRequests}, 8'b0000_0001);
    tick();
    busy = 4'b0111;
    #1;
    check_val("alloc_e3", {4'b0, writeRequests}, 8'b0000_1000);
    tick();
    dispatchValid = 1'b0;
    busy          = 4'b1101;
    requests      = 4'b1101;
    aluReady      = 1'b1;
    #1;
    check_val("age_grant", {4'b0, grants},  {4'b0, EXP_G_AGE1});
    check_val("age_exe",   {7'b0, execute}, 8'h01);
    tick();
    check_val("age_iv", {7'b0, issueValid}, 8'h01);

    // ALU not ready: nothing issues, ordering is kept
    aluReady = 1'b0;
    requests = 4'b1111;
    #1;
    check_val("nrdy_grant", {4'b0, grants},  8'h00);
    check_val("nrdy_exe",   {7'b0, execute}, 8'h00);
    tick();
    check_val("nrdy_iv", {7'b0, issueValid}, 8'h00);
    aluReady = 1'b1;
    requests = 4'b1101;
    #1;
    check_val("age_kept", {4'b0, grants}, {4'b0, EXP_G_AGE1});
    aluReady = 1'b0;
    requests = 4'b0000;
    tick();
    tick();

    // Held request is granted once only
    aluReady = 1'b1;
    requests = 4'b0001;
    #1;
    check_val("gp_first", {4'b0, grants}, 8'b0000_0001);
    tick();
    check_val("gp_second", {4'b0, grants},  8'h00);
    check_val("gp_exe",    {7'b0, execute}, 8'h00);
    requests = 4'b0000;
    tick();

    // Full station stalls dispatch
    busy          = 4'b1111;
    dispatchValid = 1'b1;
    #1;
    check_val("full_stall", {7'b0, dispatchStall}, 8'h01);
    check_val("full_wr",    {4'b0, writeRequests}, 8'h00);
    busy = 4'b1101;
    #1;
    check_val("free1_wr",    {4'b0, writeRequests}, 8'b0000_0010);
    check_val("free1_stall", {7'b0, dispatchStall}, 8'h00);
    dispatchValid = 1'b0;
    tick();
    tick();

    // Clear in the same cycle as a grant
    busy          = 4'b0000;
    dispatchValid = 1'b1;
    requests      = 4'b0001;
    aluReady      = 1'b1;
    clear         = 1'b1;
    #1;
    check_val("clr_grant", {4'b0, grants},        8'h00);
    check_val("clr_exe",   {7'b0, execute},       8'h00);
    check_val("clr_wr",    {4'b0, writeRequests}, 8'h00);
    tick();
    check_val("clr_iv", {7'b0, issueValid}, 8'h00);
    clear    = 1'b0;
    requests = 4'b0000;
    busy     = 4'b0111;
    #1;
    check_val("post_clr_e3", {4'b0, writeRequests}, 8'b0000_1000);
    tick();
    busy = 4'b1101;
    #1;
    check_val("post_clr_e1", {4'b0, writeRequests}, 8'b0000_0010);
    tick();
    dispatchValid = 1'b0;
    busy          = 4'b1010;
    requests      = 4'b1010;
    #1;
    check_val("post_clr_grant", {4'b0, grants}, {4'b0, EXP_G_CLEAR});
    tick();
    check_val("post_clr_iv", {7'b0, issueValid}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_alu_rs_scheduler
`default_nettype wire

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Controller for the four-entry ALU reservation station. Each cycle it allocates a free entry to a dispatched instruction, picks one ready entry for issue using oldest-first age ordering, and drives the station's `execute` strobe to match ALU availability. It sits between the rename/dispatch stage and the ALU reservation station, supplying the station's `writeRequests`, `grants` and `execute` inputs.

## Interface

**Parameters**
- `RS`, default 3: entry-index MSB; the station has RS+1 = 4 entries.

**Ports**
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `globalReset`, input, 1: reset, synchronous and active-high.
- `clear`, input, 1: pipeline flush. Synchronous; same effect on scheduler state as reset.
- `dispatchValid`, input, 1: an ALU instruction is presented for allocation this cycle.
- `aluReady`, input, 1: the ALU can accept an instruction at the next edge.
- `busy`, input, RS+1: entry-occupied flags from the station.
- `requests`, input, RS+1: per-entry select requests (entry busy with both operands ready).
- `writeRequests`, output, RS+1: one-hot allocation strobe to the station entries.
- `dispatchStall`, output, 1: no entry is free, so the dispatch stage must hold.
- `grants`, output, RS+1: one-hot issue grant to the station entries and its source muxes.
- `execute`, output, 1: the station registers the granted operands at the next edge.
- `issueValid`, output, 1: registered. The station output registers hold a valid instruction this cycle.

## Operation
- **Free vector:** `free = ~busy & ~allocPend`. `allocPend` is a registered copy of last cycle's `writeRequests`; it covers the one cycle before `busy` reflects the write.
- **Allocation:**
  - `writeRequests` is the lowest-index set bit of `free`, gated by `dispatchValid & ~clear & ~globalReset`.
  - `dispatchStall = dispatchValid & (free == 0)`.
- **Eligible vector:** `eligible = requests & ~grantPend`. `grantPend` is a registered copy of last cycle's issued `grants`; it prevents the same entry being granted twice before its busy flag drops.
- **Age matrix** (RS+1 × RS+1 bits; `age[i][j]=1` means entry i is older than entry j):
  - On allocation of entry k, clear row k and set `age[i][k]=1` for every i≠k.
  - Entries are never deallocated from the matrix explicitly. Stale rows are harmless because the next allocation rewrites them.
- **Selection:**
  - Entry i is granted iff `eligible[i]` and no j≠i has `eligible[j] & age[j][i]`.
  - `grants` is one-hot or zero.
  - `grants` and `execute` are both zero when `aluReady=0`, `clear` or `globalReset` is high.
- **Execute:** `execute = |grants`.
- **Issue valid:** `issueValid <= execute` at each edge.
- **Simultaneous events:**
  - Allocation and issue in the same cycle are independent.
  - An entry allocated in cycle t is not eligible before t+2, because `requests` derives from the registered entry.
- **Reset or clear:** `age`, `allocPend`, `grantPend` and `issueValid` go to 0 at the next edge. A clear mid-operation discards any pending grant.

## Timing
- Reset values: `issueValid=0`. Combinational outputs (`writeRequests`, `grants`, `execute`, `dispatchStall`) are 0 while reset is asserted.
- Allocation latency: `writeRequests` is combinational in the same cycle as `dispatchValid`. The entry is written at the next edge.
- Issue latency: `grants` and `execute` are combinational in the cycle `requests` is seen. `issueValid` rises one cycle later, aligned with the station's registered `src1`/`src2`.
- Throughput: one allocation and one issue per cycle.
- Full condition: with all four entries busy and `dispatchValid=1`, `dispatchStall=1` and `writeRequests=0`.

## Configuration
- Macro: `ALU_SCHED_AGE_EN`.
- **Defined:** oldest-first selection via the age matrix, as above.
- **Undefined:**
  - The age matrix is not built.
  - Selection is fixed priority, lowest eligible index wins.
  - All other behaviour (allocation, `allocPend`, `grantPend`, `issueValid`) is unchanged.

## Structure
- **Shared package `alu_sched_pkg`:**
  - `localparam RS_ENTRIES = RS+1`.
  - `typedef logic [RS:0] rs_vec_t`.
  - `typedef rs_vec_t [RS:0] age_mat_t`.
  - Function `lowest_set(rs_vec_t)` returning a one-hot vector.
- **Sub-module `alu_age_select`:** holds the age matrix and the oldest-first pick. It is replaced by the `lowest_set` call when `ALU_SCHED_AGE_EN` is undefined.

## Test plan
- Reset, then `busy=0000`, `dispatchValid=1` → `writeRequests=0001`. Next cycle, with `busy` still `0000` → `writeRequests=0010`.
- Allocate entries in order 2, 0, 3; raise `requests=1101`, `aluReady=1` → `grants=0100`, `execute=1`, `issueValid=1` one cycle later. With the macro undefined → `grants=0001`.
- `busy=1111`, `dispatchValid=1` → `dispatchStall=1`, `writeRequests=0000`. Drop `busy[1]` → `writeRequests=0010`, `dispatchStall=0`.
- `requests=0001` held for two cycles → grant in the first cycle only (`grantPend`); `grants=0000` in the second.
- `aluReady=0` with `requests=1111` → `grants=0`, `execute=0`, and the age matrix is unchanged.
- Assert `clear` in the same cycle as a grant → `execute=0`, `issueValid=0` next cycle. After clear, allocating entries 3 then 1 with `requests=1010` → `grants=1000`.
